// File: rtl/value_display_seq.sv
// Multi-digit decimal readout overlay with an optional unit glyph.
// A serial double-dabble engine converts each sampled reading to BCD, and the
// result is committed only at frame start so that digits never tear mid-frame.

// Seven-segment style 16x32 glyph generator for codes 0-9 and A, b, C, d, E, F.
module font16x32 (
    input  logic [3:0] code_i,
    input  logic [3:0] col_i,
    input  logic [4:0] row_i,
    output logic       pixel_o
);
    // Segment set per code, bit 6 = a (top) ... bit 0 = g (middle)
    logic [6:0] seg;
    // Which segment areas the current cell pixel falls into
    logic [6:0] region;

    // Character code to lit segments
    always_comb begin
        case (code_i)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
    end

    // Segment geometry: 3-pixel strokes inside the 16x32 cell
    always_comb begin
        region    = '0;
        region[6] = (row_i >= 5'd1)  && (row_i <= 5'd3)  && (col_i >= 4'd3)  && (col_i <= 4'd12);
        region[5] = (col_i >= 4'd12) && (col_i <= 4'd14) && (row_i >= 5'd2)  && (row_i <= 5'd16);
        region[4] = (col_i >= 4'd12) && (col_i <= 4'd14) && (row_i >= 5'd15) && (row_i <= 5'd29);
        region[3] = (row_i >= 5'd28) && (row_i <= 5'd30) && (col_i >= 4'd3)  && (col_i <= 4'd12);
        region[2] = (col_i >= 4'd1)  && (col_i <= 4'd3)  && (row_i >= 5'd15) && (row_i <= 5'd29);
        region[1] = (col_i >= 4'd1)  && (col_i <= 4'd3)  && (row_i >= 5'd2)  && (row_i <= 5'd16);
        region[0] = (row_i >= 5'd15) && (row_i <= 5'd17) && (col_i >= 4'd3)  && (col_i <= 4'd12);
    end

    assign pixel_o = |(seg & region);
endmodule

module value_display_seq #(
    parameter int         X1            = 0,
    parameter int         Y1            = 0,
    parameter int         WIDTH         = 8,
    parameter int         DIGITS        = 3,
    parameter int         BLANK_LEADING = 1,
    parameter int         SUFFIX_EN     = 1,
    parameter logic [3:0] SUFFIX_CODE   = 4'hA
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      value,
    input  logic                  value_valid,
    input  logic                  frame_start,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    output logic                  on_display,
    output logic                  busy,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_shown
);
    localparam int          ACC_W   = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(WIDTH + 1);
    localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_FRAME} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sr_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_next_q;
    logic               pend_q;
    logic [WIDTH-1:0]   pend_val_q;
    logic [ACC_W-1:0]   bcd_shown_q;
    logic               overflow_q;
    logic               on_display_q;
    logic               on_display_d;
    logic [ACC_W-1:0]   acc_shift_d;

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    function automatic logic [ACC_W-1:0] dabble_adj(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // True when the reading cannot be shown in DIGITS decimal places
    function automatic logic ovf_of(input logic [WIDTH-1:0] v);
        return 32'(v) > MAX_VAL;
    endfunction

    // Corrected accumulator shifted left with the next binary bit entering at the bottom
    always_comb begin
        acc_shift_d = dabble_adj(acc_q);
        acc_shift_d = {acc_shift_d[ACC_W-2:0], sr_q[WIDTH-1]};
    end

    // Conversion / commit sequencer with one-deep last-wins pending slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_next_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_val_q  <= '0;
            bcd_shown_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (value_valid) begin
                        sr_q       <= value;
                        ovf_next_q <= ovf_of(value);
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_shift_d;
                    sr_q  <= sr_q << 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= WAIT_FRAME;
                    if (value_valid) begin
                        pend_q     <= 1'b1;
                        pend_val_q <= value;
                    end
                end
                WAIT_FRAME: begin
                    if (value_valid) begin
                        pend_q     <= 1'b1;
                        pend_val_q <= value;
                    end
                    if (frame_start) begin
                        bcd_shown_q <= ovf_next_q ? {DIGITS{4'h9}} : acc_q;
                        overflow_q  <= ovf_next_q;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        if (pend_q) begin
                            // Older pending value converts now; a same-cycle strobe stays pending
                            sr_q       <= pend_val_q;
                            ovf_next_q <= ovf_of(pend_val_q);
                            pend_q     <= value_valid;
                            state_q    <= SHIFT;
                        end else if (value_valid) begin
                            // Same-cycle strobe with an empty slot converts directly
                            sr_q       <= value;
                            ovf_next_q <= ovf_of(value);
                            pend_q     <= 1'b0;
                            state_q    <= SHIFT;
                        end else begin
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pixel hit testing and glyph lookup
    logic [10:0]       dy;
    logic              row_hit;
    logic [DIGITS-1:0] cell_hit;
    logic [DIGITS-1:0] cell_pix;
    logic [DIGITS-1:0] lead_zero;
    logic              suffix_lit;

    assign dy      = {1'b0, y} - 11'(Y1);
    assign row_hit = dy < 11'd32;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        localparam int LEFT = X1 + 16 * (DIGITS - 1 - g);
        logic [10:0] dx;
        assign dx          = {1'b0, x} - 11'(LEFT);
        assign cell_hit[g] = (dx < 11'd16) && row_hit;
        font16x32 u_font (
            .code_i  (bcd_shown_q[4*g +: 4]),
            .col_i   (dx[3:0]),
            .row_i   (dy[4:0]),
            .pixel_o (cell_pix[g])
        );
    end

    if (SUFFIX_EN != 0) begin : g_suffix
        localparam int LEFT = X1 + 16 * DIGITS;
        logic [10:0] dx;
        logic        pix;
        assign dx = {1'b0, x} - 11'(LEFT);
        font16x32 u_font (
            .code_i  (SUFFIX_CODE),
            .col_i   (dx[3:0]),
            .row_i   (dy[4:0]),
            .pixel_o (pix)
        );
        assign suffix_lit = (dx < 11'd16) && row_hit && pix;
    end else begin : g_no_suffix
        assign suffix_lit = 1'b0;
    end

    // Leading-zero run from the MS digit downward, then OR of unmasked cell pixels
    always_comb begin
        lead_zero             = '0;
        lead_zero[DIGITS-1]   = (bcd_shown_q[ACC_W-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (bcd_shown_q[4*i +: 4] == 4'd0);
        end
        on_display_d = suffix_lit;
        for (int i = 0; i < DIGITS; i++) begin
            if (cell_hit[i] && cell_pix[i] && !((BLANK_LEADING != 0) && (i > 0) && lead_zero[i])) begin
                on_display_d = 1'b1;
            end
        end
    end

    // Registered pixel output, one cycle behind x/y
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) on_display_q <= 1'b0;
        else          on_display_q <= on_display_d;
    end

    assign on_display = on_display_q;
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;
    assign bcd_shown  = bcd_shown_q;
endmodule

// File: tb/tb_value_display_seq.sv
// Directed bench for value_display_seq: a 3-digit instance with '%'-style
// suffix at (100,50) and a 2-digit instance at (300,100) share all inputs.
module tb_value_display_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  value;
    logic        value_valid;
    logic        frame_start;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        od_a, busy_a, ovf_a;
    logic [11:0] bcd_a;
    logic        od_b, busy_b, ovf_b;
    logic [7:0]  bcd_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    value_display_seq #(.X1(100), .Y1(50), .WIDTH(8), .DIGITS(3),
                        .BLANK_LEADING(1), .SUFFIX_EN(1), .SUFFIX_CODE(4'hA)) u_a (
        .clk(clk), .reset_n(reset_n), .value(value), .value_valid(value_valid),
        .frame_start(frame_start), .x(x), .y(y), .on_display(od_a), .busy(busy_a),
        .overflow(ovf_a), .bcd_shown(bcd_a));

    value_display_seq #(.X1(300), .Y1(100), .WIDTH(8), .DIGITS(2),
                        .BLANK_LEADING(1), .SUFFIX_EN(1), .SUFFIX_CODE(4'hA)) u_b (
        .clk(clk), .reset_n(reset_n), .value(value), .value_valid(value_valid),
        .frame_start(frame_start), .x(x), .y(y), .on_display(od_b), .busy(busy_b),
        .overflow(ovf_b), .bcd_shown(bcd_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] v);
        value       = v;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic px(input int xx, input int yy);
        x = 10'(xx);
        y = 10'(yy);
        tick();
    endtask

    initial begin
        int lit_in, lit_out, busy_cnt;
        logic saw50;
        reset_n = 1'b1; value = '0; value_valid = 1'b0; frame_start = 1'b0;
        x = '0; y = '0;
        #2 reset_n = 1'b0;
        #10;
        check("rst_bcd",  32'(bcd_a), 32'h000);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_ovf",  32'(ovf_a), 0);
        check("rst_od",   32'(od_a), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        tick();

        // Blank scan: only the ones cell (132..147) and suffix cell (148..163) may light
        lit_in = 0; lit_out = 0;
        for (int yy = 48; yy <= 83; yy++) begin
            for (int xx = 96; xx <= 167; xx++) begin
                px(xx, yy);
                if (od_a) begin
                    if (xx >= 132 && xx <= 163 && yy >= 50 && yy <= 81) lit_in++;
                    else lit_out++;
                end
            end
        end
        check("scan_outside_lit", 32'(lit_out), 0);
        check("scan_inside_some", 32'(lit_in > 0), 1);
        px(140, 52); check("zero_top_seg",   32'(od_a), 1);
        px(140, 66); check("zero_mid_dark",  32'(od_a), 0);
        px(156, 66); check("suffix_mid_seg", 32'(od_a), 1);
        px(108, 52); check("hund_blanked",   32'(od_a), 0);

        // 157: busy through edges 0..19, commit on frame_start at edge 20
        busy_cnt = 0;
        strobe(8'd157);
        if (busy_a) busy_cnt++;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (busy_a) busy_cnt++;
        end
        check("busy_cycles",   32'(busy_cnt), 20);
        check("pre_commit",    32'(bcd_a), 32'h000);
        frame();
        check("bcd_157",       32'(bcd_a), 32'h157);
        check("ovf_157",       32'(ovf_a), 0);
        check("idle_157",      32'(busy_a), 0);
        check("b_bcd_157",     32'(bcd_b), 32'h99);
        check("b_ovf_157",     32'(ovf_b), 1);
        px(108, 52); check("one_top_dark", 32'(od_a), 0);
        px(113, 58); check("one_right_lit", 32'(od_a), 1);

        // frame_start during SHIFT is ignored
        strobe(8'd38);
        tick(); tick(); tick();
        frame();
        check("shift_frame_bcd",  32'(bcd_a), 32'h157);
        check("shift_frame_busy", 32'(busy_a), 1);
        for (int k = 0; k < 10; k++) tick();
        check("wait_bcd",  32'(bcd_a), 32'h157);
        check("wait_busy", 32'(busy_a), 1);
        frame();
        check("bcd_038",   32'(bcd_a), 32'h038);
        check("idle_038",  32'(busy_a), 0);

        // Two-digit instance: saturation then small value with blanked tens
        strobe(8'd200);
        for (int k = 0; k < 9; k++) tick();
        frame();
        check("b_bcd_200", 32'(bcd_b), 32'h99);
        check("b_ovf_200", 32'(ovf_b), 1);
        check("a_bcd_200", 32'(bcd_a), 32'h200);
        check("a_ovf_200", 32'(ovf_a), 0);
        strobe(8'd7);
        for (int k = 0; k < 9; k++) tick();
        frame();
        check("b_bcd_7", 32'(bcd_b), 32'h07);
        check("b_ovf_7", 32'(ovf_b), 0);
        px(308, 102); check("b_tens_dark",    32'(od_b), 0);
        px(324, 102); check("b_ones_top",     32'(od_b), 1);
        px(324, 116); check("b_ones_mid",     32'(od_b), 0);
        px(340, 116); check("b_suffix_mid",   32'(od_b), 1);

        // Pending slot: 42 converts, 50 is overwritten by 63
        saw50 = 1'b0;
        strobe(8'd42);
        tick(); tick();
        strobe(8'd50);
        tick();
        strobe(8'd63);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bcd_a == 12'h050) saw50 = 1'b1;
        end
        frame();
        check("pend_bcd_042",  32'(bcd_a), 32'h042);
        check("pend_busy_042", 32'(busy_a), 1);
        for (int k = 0; k < 9; k++) begin
            tick();
            if (bcd_a == 12'h050) saw50 = 1'b1;
        end
        frame();
        check("pend_bcd_063",  32'(bcd_a), 32'h063);
        check("pend_idle_063", 32'(busy_a), 0);
        tick(); tick();
        if (bcd_a == 12'h050) saw50 = 1'b1;
        check("never_050", 32'(saw50), 0);

        // Reset mid-conversion aborts everything
        px(140, 52); check("pre_rst_od", 32'(od_a), 1);
        strobe(8'd99);
        tick(); tick(); tick();
        check("pre_rst_busy", 32'(busy_a), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_a), 0);
        check("mid_rst_bcd",  32'(bcd_a), 32'h000);
        check("mid_rst_ovf",  32'(ovf_a), 0);
        check("mid_rst_od",   32'(od_a), 0);
        check("mid_rst_bcdb", 32'(bcd_b), 32'h00);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        frame();
        check("post_rst_busy", 32'(busy_a), 0);
        check("post_rst_bcd",  32'(bcd_a), 32'h000);
        tick();
        check("post_rst_od",   32'(od_a), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/value_display_seq.md
Name: value_display_seq

Overview:
- Parametrised successor of the two-digit sensor readout overlay. Renders an N-digit decimal value plus an optional unit glyph (e.g. '%', 'C') at a fixed VGA screen position.
- Converts binary to BCD with an iterative double-dabble engine rather than a combinational converter.
- Commits new values only at frame start, so a digit never changes mid-frame (no tearing).
- Sits between the sensor-sample registers and the VGA pixel mux; one instance per displayed reading.

Parameters:
- X1, 0, left pixel column of the most-significant digit cell
- Y1, 0, top pixel row of all cells
- WIDTH, 8, binary input width (1..16)
- DIGITS, 3, displayed decimal digits (1..5); each cell is 16x32, cells are contiguous left to right
- BLANK_LEADING, 1, 1 = leading zeros not drawn (least-significant digit always drawn)
- SUFFIX_EN, 1, 1 = draw a suffix glyph cell immediately right of the last digit
- SUFFIX_CODE, 4'hA, font16x32 character code used for the suffix cell

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- value  in  WIDTH  binary reading to display
- value_valid  in  1  one-cycle strobe: sample value
- frame_start  in  1  one-cycle pulse at start of vertical blank
- x  in  10  current pixel column
- y  in  10  current pixel row
- on_display  out  1  pixel belongs to a lit glyph pixel (registered)
- busy  out  1  conversion in progress or result awaiting commit
- overflow  out  1  committed value exceeded 10^DIGITS-1
- bcd_shown  out  4*DIGITS  BCD currently displayed, MS digit in top nibble

Behaviour:
- Reset (async assert, sync release):
  - all registers cleared; FSM enters IDLE.
  - on_display=0, busy=0, overflow=0, bcd_shown=0, pending flag clear.
  - After reset the display shows "0" plus the suffix (leading zeros blanked if BLANK_LEADING).
- FSM states: IDLE, SHIFT, WAIT_FRAME.
  - IDLE:
    - on value_valid: latch value into shift register.
    - latch ovf_next = (value > 10^DIGITS-1).
    - clear BCD accumulator; count=0; go to SHIFT.
  - SHIFT:
    - each cycle: add 3 to every accumulator nibble >=5, then shift {acc, sr} left 1.
    - count increments; after exactly WIDTH cycles go to WAIT_FRAME.
    - Accumulator width is 4*DIGITS; upper bits shifted out are discarded (covered by overflow).
  - WAIT_FRAME:
    - on frame_start: commit. bcd_shown <= acc, or all 9s if ovf_next; overflow <= ovf_next.
    - then go to IDLE, or straight to SHIFT if the pending flag is set.
- busy=1 in SHIFT and WAIT_FRAME.
- Latency from value_valid to bcd_shown update = WIDTH cycles plus the wait to the next frame_start after conversion ends, plus 1 cycle. A frame_start during SHIFT is ignored.
- value_valid while busy:
  - value is copied to a one-deep pending register and the pending flag is set.
  - later strobes overwrite the pending value (last wins).
  - on commit, if pending is set: load it, clear the flag, start SHIFT the next cycle.
  - value_valid coinciding with the commit cycle counts as pending.
- Rendering:
  - digit i (i=DIGITS-1 is MS) occupies cell x ∈ [X1+16*(DIGITS-1-i), +15], y ∈ [Y1, Y1+31].
  - each cell uses a font16x32 instance fed from bcd_shown.
  - suffix cell is at X1+16*DIGITS, present only if SUFFIX_EN.
  - blanking: digit i is masked when BLANK_LEADING, i>0, and all digits from DIGITS-1 down to i are 0.
  - on_display = registered OR of unmasked cell hits; 1-cycle latency from x/y.
- Reset mid-conversion aborts with no commit; the pending value is lost.

Test Plan:
- Reset, WIDTH=8, DIGITS=3 -> bcd_shown=0x000, busy=0. Scan across the cells: only the ones cell (X1+32..X1+47) and the suffix cell ever light.
- value=8'd157, strobe, frame_start 20 cycles later -> busy for cycles 1..20 of the strobe sequence, bcd_shown=0x157 the cycle after frame_start, overflow=0.
- frame_start pulsed 4 cycles after the strobe (during SHIFT), then again later -> no change at the first pulse; commit at the second.
- DIGITS=2, value=8'd200 -> bcd_shown=0x99, overflow=1. Then value=8'd7 -> bcd_shown=0x07, overflow=0, tens cell dark, ones cell lit.
- Strobe 42, then strobes 50 and 63 while busy -> commits 0x042 and then 0x063; 50 is never shown.
- Assert reset_n=0 mid-SHIFT (cycle 3 of converting 99) -> outputs clear immediately. After release, busy=0 and bcd_shown=0x000.
